uart_boot_loader: RTL



---
 rtl/uart_boot_loader_if.sv | 12 +
 rtl/uart_boot_loader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader_if.sv
// Program-memory write port: request held until ack.
interface uart_boot_loader_if #(
  parameter int ADDR_W = 5
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  modport master (output mem_we, mem_addr, mem_wdata, input mem_ack);
  modport slave  (input mem_we, mem_addr, mem_wdata, output mem_ack);
endinterface

// File: rtl/uart_boot_loader.sv
// UART 8N1 receiver packing bytes LSB-first into 32-bit words written to
// program memory; holds the CPU in reset until WORDS words are stored.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int WORDS        = 32,
  parameter int ADDR_W       = 5
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               uart_rx,
  uart_boot_loader_if.master mem,
  output logic               cpu_rst,
  output logic               load_done,
  output logic               frame_err,
  output logic               overrun
);
  localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CW-1:0]    HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]    FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [1:0] {LD_LOAD, LD_WRITE, LD_DONE} ld_st_t;

  logic          rx_meta, rx_s;
  rx_st_t        rx_st, rx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    sh, sh_nxt;
  logic          brk, brk_nxt;
  logic          bv_nxt, ferr_hit, byte_valid;

  ld_st_t           ld_st, ld_nxt;
  logic [CNT_W-1:0] word_cnt;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_buf;
  logic [31:0]      word, pend_data;
  logic             pend_vld, word_done, last;

  // ---------------- RX ----------------
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_st      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      sh         <= '0;
      brk        <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      rx_meta    <= uart_rx;
      rx_s       <= rx_meta;
      rx_st      <= rx_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_nxt;
      sh         <= sh_nxt;
      brk        <= brk_nxt;
      byte_valid <= bv_nxt;
    end

  always_comb begin
    rx_nxt   = rx_st;
    cnt_nxt  = cnt;
    bit_nxt  = bit_idx;
    sh_nxt   = sh;
    brk_nxt  = brk;
    bv_nxt   = 1'b0;
    ferr_hit = 1'b0;
    case (rx_st)
      RX_IDLE:
        if (!rx_s) begin
          cnt_nxt = HALF;
          rx_nxt  = RX_START;
        end
      RX_START:
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else if (!rx_s) begin
          cnt_nxt = FULL;
          bit_nxt = '0;
          rx_nxt  = RX_DATA;
        end else rx_nxt = RX_IDLE;
      RX_DATA:
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else begin
          sh_nxt  = {rx_s, sh[7:1]};
          cnt_nxt = FULL;
          bit_nxt = bit_idx + 1'b1;
          if (bit_idx == 3'd7) rx_nxt = RX_STOP;
        end
      RX_STOP:
        // After a low stop bit, park here until the line returns high so a
        // break cannot be mistaken for a new start bit.
        if (brk) begin
          if (rx_s) begin
            brk_nxt = 1'b0;
            rx_nxt  = RX_IDLE;
          end
        end else if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else if (rx_s) begin
          bv_nxt = 1'b1;
          rx_nxt = RX_IDLE;
        end else begin
          ferr_hit = 1'b1;
          brk_nxt  = 1'b1;
        end
      default: rx_nxt = RX_IDLE;
    endcase
  end

  // ---------------- loader ----------------
  assign word      = {sh, word_buf};
  assign word_done = byte_valid && (byte_cnt == 2'd3) && (ld_st != LD_DONE);
  assign last      = (word_cnt == LAST);

  assign mem.mem_we   = (ld_st == LD_WRITE);
  assign mem.mem_addr = word_cnt[ADDR_W-1:0];
  assign load_done    = (ld_st == LD_DONE);
  assign cpu_rst      = ~load_done;

  always_comb begin
    ld_nxt = ld_st;
    case (ld_st)
      LD_LOAD:  if (word_done || pend_vld) ld_nxt = LD_WRITE;
      LD_WRITE: if (mem.mem_ack) ld_nxt = last ? LD_DONE : LD_LOAD;
      LD_DONE:  ld_nxt = LD_DONE;
      default:  ld_nxt = LD_LOAD;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      ld_st         <= LD_LOAD;
      word_cnt      <= '0;
      byte_cnt      <= '0;
      word_buf      <= '0;
      pend_vld      <= 1'b0;
      pend_data     <= '0;
      mem.mem_wdata <= '0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      ld_st    <= ld_nxt;
      pend_vld <= 1'b0;
      if (ld_st == LD_LOAD && ld_nxt == LD_WRITE)
        mem.mem_wdata <= pend_vld ? pend_data : word;
      if (ld_st == LD_WRITE && mem.mem_ack)
        word_cnt <= word_cnt + 1'b1;
      // A word landing on the ack cycle is held one cycle; otherwise a word
      // arriving during a write is lost.
      if (ld_st == LD_WRITE && word_done) begin
        if (!mem.mem_ack) overrun <= 1'b1;
        else if (!last) begin
          pend_vld  <= 1'b1;
          pend_data <= word;
        end
      end
      if (byte_valid && ld_st != LD_DONE) begin
        byte_cnt <= byte_cnt + 1'b1;
        case (byte_cnt)
          2'd0:    word_buf[7:0]   <= sh;
          2'd1:    word_buf[15:8]  <= sh;
          2'd2:    word_buf[23:16] <= sh;
          default: ;
        endcase
      end
      if (ferr_hit && ld_st != LD_DONE) frame_err <= 1'b1;
    end
endmodule
